branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Execute-side counterpart to the front-end dispatch stall FSM.
- Tracks the single outstanding branch or JALR that dispatch stalled on and watches the common data bus (CDB) for its result.
- Returns branch_solved/jalr_solved to the stall logic.
- On a taken branch or any JALR, issues a fetch redirect and an IFQ flush.

Parameters:
TAG_W, 6, width of ROB/CDB tag
XLEN, 32, PC/target width

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous reset, active-low (asserted when 0)
disp_branch  in  1  conditional branch dispatched this cycle
disp_jalr  in  1  JALR dispatched this cycle
disp_tag  in  TAG_W  ROB tag of dispatched control instruction
disp_pc  in  XLEN  PC of dispatched control instruction
cdb_valid  in  1  CDB broadcast valid
cdb_tag  in  TAG_W  CDB tag
cdb_taken  in  1  branch outcome (ignored for JALR)
cdb_target  in  XLEN  computed target address
branch_solved  out  1  one-cycle pulse: tracked branch resolved
jalr_solved  out  1  one-cycle pulse: tracked JALR resolved
redirect_valid  out  1  one-cycle pulse: fetch must restart at redirect_pc
redirect_pc  out  XLEN  redirect address (held until next resolve)
ifq_flush  out  1  one-cycle pulse: discard IFQ contents
busy  out  1  1 while WAIT_BR or WAIT_JALR
protocol_err  out  1  sticky: illegal dispatch sequence seen

Behaviour:
- Reset is synchronous. When rst=0 at a clock edge:
  - state=IDLE.
  - All outputs, the captured tag and the captured PC go to 0.
  - Reset mid-wait abandons the tracked instruction; no solved pulse is issued.
- The state machine has three states: IDLE, WAIT_BR, WAIT_JALR. busy = (state != IDLE), combinational from state.
- IDLE:
  - disp_branch=1: capture disp_tag, disp_pc; go to WAIT_BR.
  - Else disp_jalr=1: capture; go to WAIT_JALR.
  - disp_branch and disp_jalr both 1: branch wins and protocol_err is set.
  - A CDB broadcast in IDLE is ignored, including one in the same cycle as a dispatch.
- WAIT_BR, match = cdb_valid & (cdb_tag == captured tag):
  - No match: stay.
  - Match: next edge → IDLE and register the outputs for one cycle:
    - branch_solved=1.
    - cdb_taken=1: redirect_valid=1, ifq_flush=1, redirect_pc=cdb_target.
    - cdb_taken=0: redirect_valid=0, ifq_flush=0, redirect_pc=captured_pc+4 (informational).
- WAIT_JALR:
  - On match, next edge → IDLE with jalr_solved=1, redirect_valid=1, ifq_flush=1, redirect_pc = cdb_target with bit0 forced to 0.
- Latency: match in cycle N → pulses high during cycle N+1 only; state is IDLE in N+1, so a new dispatch in N+1 is accepted.
- Dispatch while busy (disp_branch|disp_jalr in WAIT_*): the dispatch is ignored, the tracked tag is unchanged, protocol_err=1.
- protocol_err clears only on reset.
- Pulse outputs are registered and default to 0 every cycle they are not set.
- PC arithmetic is modulo 2^XLEN: PC 0xFFFFFFFC + 4 wraps to 0x00000000.
- A non-matching CDB tag has no effect in any state.

Test Plan:
1. Reset: hold rst=0 for 2 cycles with disp_branch=1 → busy=0, all pulses 0, protocol_err=0, redirect_pc=0.
2. Taken branch:
   - Stimulus: dispatch branch tag=5 pc=0x100; CDB tag=5 taken=1 target=0x200 three cycles later.
   - Response: busy=1 for 3 cycles; next cycle branch_solved=1, redirect_valid=1, ifq_flush=1, redirect_pc=0x200; busy=0.
3. Not-taken branch:
   - Stimulus: tag=7 pc=0xFFFFFFFC; CDB tag=3 (no effect), then tag=7 taken=0.
   - Response: branch_solved=1, redirect_valid=0, ifq_flush=0, redirect_pc=0x0.
4. JALR: dispatch JALR tag=9; CDB tag=9 target=0x1235 → jalr_solved=1, branch_solved=0, redirect_pc=0x1234, flush=1.
5. Protocol errors:
   - disp_branch=disp_jalr=1 in IDLE → WAIT_BR, protocol_err=1.
   - Second dispatch tag=2 while waiting on tag=1 → CDB tag=2 gives no pulse; tag=1 resolves normally.
6. Edge timing:
   - Reset asserted in WAIT_BR → IDLE, no pulse afterwards even when CDB matches the old tag.
   - Dispatch in the cycle right after a resolve pulse → accepted, busy=1 the next cycle.

Source files
------------

// File: rtl/branch_resolver.sv
// Execute-side resolver for the single control instruction the dispatch stall FSM waits on.
// Watches the CDB for its tag and issues solved pulses plus fetch redirect / IFQ flush.
module branch_resolver #(
  parameter int TAG_W = 6,
  parameter int XLEN  = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             disp_branch,
  input  logic             disp_jalr,
  input  logic [TAG_W-1:0] disp_tag,
  input  logic [XLEN-1:0]  disp_pc,
  input  logic             cdb_valid,
  input  logic [TAG_W-1:0] cdb_tag,
  input  logic             cdb_taken,
  input  logic [XLEN-1:0]  cdb_target,
  output logic             branch_solved,
  output logic             jalr_solved,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             ifq_flush,
  output logic             busy,
  output logic             protocol_err
);

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] WAIT_BR   = 2'd1;
  localparam logic [1:0] WAIT_JALR = 2'd2;

  logic [1:0]       state;
  logic [TAG_W-1:0] tag_q;
  logic [XLEN-1:0]  pc_q;
  logic             match;

  assign match = cdb_valid && (cdb_tag == tag_q);
  assign busy  = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state          <= IDLE;
      tag_q          <= '0;
      pc_q           <= '0;
      branch_solved  <= 1'b0;
      jalr_solved    <= 1'b0;
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      ifq_flush      <= 1'b0;
      protocol_err   <= 1'b0;
    end else begin
      branch_solved  <= 1'b0;
      jalr_solved    <= 1'b0;
      redirect_valid <= 1'b0;
      ifq_flush      <= 1'b0;
      case (state)
        IDLE: begin
          // CDB traffic is ignored here, even alongside a dispatch
          if (disp_branch) begin
            tag_q <= disp_tag;
            pc_q  <= disp_pc;
            state <= WAIT_BR;
            if (disp_jalr) protocol_err <= 1'b1;
          end else if (disp_jalr) begin
            tag_q <= disp_tag;
            pc_q  <= disp_pc;
            state <= WAIT_JALR;
          end
        end
        WAIT_BR: begin
          if (disp_branch || disp_jalr) protocol_err <= 1'b1;
          if (match) begin
            state         <= IDLE;
            branch_solved <= 1'b1;
            if (cdb_taken) begin
              redirect_valid <= 1'b1;
              ifq_flush      <= 1'b1;
              redirect_pc    <= cdb_target;
            end else begin
              redirect_pc <= pc_q + XLEN'(4);
            end
          end
        end
        WAIT_JALR: begin
          if (disp_branch || disp_jalr) protocol_err <= 1'b1;
          if (match) begin
            state          <= IDLE;
            jalr_solved    <= 1'b1;
            redirect_valid <= 1'b1;
            ifq_flush      <= 1'b1;
            redirect_pc    <= {cdb_target[XLEN-1:1], 1'b0};
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_branch_resolver.sv
// Directed bench for branch_resolver: expected resolve pulses go into a queue that a
// negedge monitor drains whenever the DUT pulses a solved output.
module tb_branch_resolver;
  localparam int TAG_W = 6;
  localparam int XLEN  = 32;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             disp_branch = 1'b0, disp_jalr = 1'b0;
  logic [TAG_W-1:0] disp_tag = '0;
  logic [XLEN-1:0]  disp_pc = '0;
  logic             cdb_valid = 1'b0, cdb_taken = 1'b0;
  logic [TAG_W-1:0] cdb_tag = '0;
  logic [XLEN-1:0]  cdb_target = '0;
  logic             branch_solved, jalr_solved, redirect_valid, ifq_flush, busy, protocol_err;
  logic [XLEN-1:0]  redirect_pc;

  int compared = 0;
  int mismatched = 0;
  // {branch_solved, jalr_solved, redirect_valid, ifq_flush, redirect_pc}
  logic [XLEN+3:0] exp_q[$];

  branch_resolver #(.TAG_W(TAG_W), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .disp_branch(disp_branch), .disp_jalr(disp_jalr), .disp_tag(disp_tag), .disp_pc(disp_pc),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_taken(cdb_taken), .cdb_target(cdb_target),
    .branch_solved(branch_solved), .jalr_solved(jalr_solved), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .ifq_flush(ifq_flush), .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Monitor: every solved pulse must match the oldest expected resolution.
  always @(negedge clk) begin
    logic [XLEN+3:0] got, exp;
    if (branch_solved || jalr_solved) begin
      got = {branch_solved, jalr_solved, redirect_valid, ifq_flush, redirect_pc};
      compared++;
      if (exp_q.size() == 0) begin
        mismatched++;
        $display("FAIL unexpected_pulse: got %h, none expected at %0t", got, $time);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp) begin
          mismatched++;
          $display("FAIL resolve: got %h expected %h at %0t", got, exp, $time);
        end
      end
    end
  end

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] req);
    compared++;
    if (act !== req) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic dispatch(input logic br, input logic jr, input logic [TAG_W-1:0] t, input logic [XLEN-1:0] pc);
    disp_branch = br; disp_jalr = jr; disp_tag = t; disp_pc = pc;
  endtask

  task automatic cdb(input logic v, input logic [TAG_W-1:0] t, input logic tk, input logic [XLEN-1:0] tgt);
    cdb_valid = v; cdb_tag = t; cdb_taken = tk; cdb_target = tgt;
  endtask

  initial begin
    // 1. reset held two cycles with a dispatch present
    dispatch(1, 0, 6'd3, 32'h50);
    cyc(); cyc();
    check("rst_busy", 32'(busy), 0);
    check("rst_perr", 32'(protocol_err), 0);
    check("rst_redirect_pc", redirect_pc, 0);
    check("rst_pulses", {28'd0, branch_solved, jalr_solved, redirect_valid, ifq_flush}, 0);
    dispatch(0, 0, 0, 0);
    rst = 1'b1;
    cyc();
    check("idle_busy", 32'(busy), 0);

    // 2. taken branch, resolved three cycles after dispatch
    dispatch(1, 0, 6'd5, 32'h100); cyc(); dispatch(0, 0, 0, 0);
    check("br_busy1", 32'(busy), 1); cyc();
    check("br_busy2", 32'(busy), 1); cyc();
    check("br_busy3", 32'(busy), 1);
    cdb(1, 6'd5, 1, 32'h200);
    exp_q.push_back({4'b1011, 32'h200});
    cyc(); cdb(0, 0, 0, 0);
    check("br_done_busy", 32'(busy), 0);
    cyc();

    // 3. not-taken branch at top of address space; stray tag first
    dispatch(1, 0, 6'd7, 32'hFFFF_FFFC); cyc(); dispatch(0, 0, 0, 0);
    cdb(1, 6'd3, 1, 32'hDEAD); cyc();
    check("nt_busy_after_stray", 32'(busy), 1);
    cdb(1, 6'd7, 0, 32'h1234_5678);
    exp_q.push_back({4'b1000, 32'h0});
    cyc(); cdb(0, 0, 0, 0);
    cyc();

    // 4. JALR with odd target
    dispatch(0, 1, 6'd9, 32'h40); cyc(); dispatch(0, 0, 0, 0);
    check("jalr_busy", 32'(busy), 1);
    cdb(1, 6'd9, 0, 32'h1235);
    exp_q.push_back({4'b0111, 32'h1234});
    cyc(); cdb(0, 0, 0, 0);
    cyc();

    // 5. both dispatch bits, then a dispatch while busy
    dispatch(1, 1, 6'd1, 32'h300); cyc(); dispatch(0, 0, 0, 0);
    check("both_busy", 32'(busy), 1);
    check("both_perr", 32'(protocol_err), 1);
    dispatch(1, 0, 6'd2, 32'h400); cyc(); dispatch(0, 0, 0, 0);
    cdb(1, 6'd2, 1, 32'h999); cyc(); cdb(0, 0, 0, 0);
    check("ignored_tag_busy", 32'(busy), 1);
    cdb(1, 6'd1, 1, 32'h500);
    exp_q.push_back({4'b1011, 32'h500});
    cyc(); cdb(0, 0, 0, 0);
    check("perr_sticky", 32'(protocol_err), 1);
    cyc();

    // 6a. reset mid-wait abandons the tracked branch
    dispatch(1, 0, 6'd4, 32'h10); cyc(); dispatch(0, 0, 0, 0);
    check("pre_rst_busy", 32'(busy), 1);
    rst = 1'b0; cyc(); rst = 1'b1;
    check("midrst_busy", 32'(busy), 0);
    check("midrst_perr", 32'(protocol_err), 0);
    cdb(1, 6'd4, 1, 32'h600); cyc(); cyc(); cdb(0, 0, 0, 0);
    check("old_tag_busy", 32'(busy), 0);

    // 6b. dispatch in the pulse cycle is accepted
    dispatch(1, 0, 6'd6, 32'h20); cyc(); dispatch(0, 0, 0, 0);
    cdb(1, 6'd6, 0, 32'h0);
    exp_q.push_back({4'b1000, 32'h24});
    cyc(); cdb(0, 0, 0, 0);
    dispatch(0, 1, 6'd8, 32'h30); cyc(); dispatch(0, 0, 0, 0);
    check("b2b_busy", 32'(busy), 1);
    check("b2b_perr", 32'(protocol_err), 0);
    cdb(1, 6'd8, 1, 32'h77);
    exp_q.push_back({4'b0111, 32'h76});
    cyc(); cdb(0, 0, 0, 0);
    cyc(); cyc();

    check("queue_drained", 32'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
